branch_redirect_ctrl: RTL

Pipeline redirect controller that sits beside the EX-stage branch comparator and sequences recovery from control-flow mispredictions. Each cycle it compares the resolved outcome and target of the instruction in EX with the prediction carried down the pipe. On a mismatch it squashes the IF/ID and ID/EX registers and drives a redirect request to the fetch unit. The redirect request uses a valid/ready handshake and is held until fetch accepts it. The block also keeps resolved-branch and mispredict counters for performance analysis.

---
 rtl/branch_redirect_ctrl_if.sv | 32 +++
 rtl/branch_redirect_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage resolution inputs and fetch redirect/flush outputs of the redirect controller.
// The controller holds the master side; the pipeline/fetch side holds the slave side.
interface branch_redirect_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  ex_valid;
   logic                  ex_stall;
   logic [2:0]            ex_branch_sel;
   logic                  ex_pc_sel;
   logic [ADDR_WIDTH-1:0] ex_target;
   logic [ADDR_WIDTH-1:0] ex_pc_plus4;
   logic                  ex_pred_taken;
   logic [ADDR_WIDTH-1:0] ex_pred_target;
   logic                  redirect_ready;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  flush_if_id;
   logic                  flush_id_ex;
   logic                  hold_fetch;

   modport master (
      input  ex_valid, ex_stall, ex_branch_sel, ex_pc_sel, ex_target, ex_pc_plus4,
             ex_pred_taken, ex_pred_target, redirect_ready,
      output redirect_valid, redirect_pc, flush_if_id, flush_id_ex, hold_fetch
   );

   modport slave (
      output ex_valid, ex_stall, ex_branch_sel, ex_pc_sel, ex_target, ex_pc_plus4,
             ex_pred_taken, ex_pred_target, redirect_ready,
      input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex, hold_fetch
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Detects EX-stage control-flow mispredicts, squashes younger stages and holds a
// valid/ready redirect to fetch until accepted; keeps branch/mispredict counters.
module branch_redirect_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_redirect_ctrl_if.master bus,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] mispredict_cnt
);
   localparam logic [2:0] SEL_NONE = 3'b010;
   localparam logic [2:0] SEL_JUMP = 3'b011;

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

   logic                  ex_fire;
   logic                  is_ctrl;
   logic                  taken;
   logic                  dir_wrong;
   logic                  tgt_wrong;
   logic                  mispredict;
   logic [ADDR_WIDTH-1:0] correct_pc;

   // Resolution of the instruction currently in EX.
   always_comb begin
      ex_fire    = bus.ex_valid & ~bus.ex_stall;
      is_ctrl    = (bus.ex_branch_sel != SEL_NONE);
      taken      = is_ctrl & ((bus.ex_branch_sel == SEL_JUMP) | bus.ex_pc_sel);
      dir_wrong  = (taken != bus.ex_pred_taken);
      tgt_wrong  = taken & bus.ex_pred_taken & (bus.ex_target != bus.ex_pred_target);
      // A non-control instruction predicted taken falls out as a direction mispredict.
      mispredict = ex_fire & (dir_wrong | tgt_wrong);
      correct_pc = taken ? bus.ex_target : bus.ex_pc_plus4;
   end

   always_comb begin
      state_d            = state_q;
      pend_pc_d          = pend_pc_q;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.flush_if_id    = 1'b0;
      bus.flush_id_ex    = 1'b0;
      bus.hold_fetch     = 1'b0;
      case (state_q)
         IDLE: begin
            if (mispredict) begin
               bus.redirect_valid = 1'b1;
               bus.redirect_pc    = correct_pc;
               bus.flush_if_id    = 1'b1;
               bus.flush_id_ex    = 1'b1;
               if (!bus.redirect_ready) begin
                  pend_pc_d = correct_pc;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            // EX carries a bubble here, so only the IF/ID squash is needed.
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = pend_pc_q;
            bus.flush_if_id    = 1'b1;
            bus.hold_fetch     = 1'b1;
            if (bus.redirect_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (cnt_clr) begin
         branch_cnt_d     = '0;
         mispredict_cnt_d = '0;
      end else if (state_q == IDLE) begin
         if (ex_fire && is_ctrl) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
         end
         if (mispredict) begin
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         pend_pc_q        <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         state_q          <= state_d;
         pend_pc_q        <= pend_pc_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;
endmodule
